ddio_bidir_sequencer: RTL and testbench

DDIO_BIDIR_SEQUENCER -- requirements
Module: ddio_bidir_sequencer

---
 rtl/ddio_seq_pkg.sv | 23 ++
 rtl/ddio_rd_capture.sv | 50 +++++
 rtl/ddio_bidir_sequencer.sv | 158 +++++++++++++++
 tb/tb_ddio_bidir_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddio_seq_pkg.sv
// Shared types and helpers for the DDIO bidirectional burst sequencer.
package ddio_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } seq_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_READ,
    DIR_WRITE
  } dir_e;

  // Width of the beats-minus-one length field; never narrower than one bit.
  function automatic int len_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/ddio_rd_capture.sv
// Read-side valid pipe and capture register. One token enters per READ beat;
// when it reaches the end of the pipe the pad data is registered and flagged.
module ddio_rd_capture #(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     dataout_h_i,
  input  logic [WIDTH-1:0]     dataout_l_i,
  output logic                 pipe_active_o,
  output logic                 rd_valid_o,
  output logic [2*WIDTH-1:0]   rd_data_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic                    rd_valid_q;
  logic [2*WIDTH-1:0]      rd_data_q;

  // Shift the beat tokens towards the capture point.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Register the pad data on the cycle its token leaves the pipe.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= vld_q[READ_LATENCY-1];
      if (vld_q[READ_LATENCY-1]) begin
        rd_data_q <= {dataout_h_i, dataout_l_i};
      end
    end
  end

  assign pipe_active_o = |vld_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;

endmodule

// File: rtl/ddio_bidir_sequencer.sv
// Burst sequencer for a bidirectional DDIO pad atom: accepts read/write
// commands, inserts bus turnaround between opposite directions, streams write
// beats onto the pads and collects read beats after the pad latency.
module ddio_bidir_sequencer
  import ddio_seq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_BURST    = 16,
  parameter int TURNAROUND   = 2,
  parameter int READ_LATENCY = 3,
  localparam int LEN_W       = len_w(MAX_BURST)
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               wr_ready,
  input  logic [2*WIDTH-1:0] wr_data,
  output logic               rd_valid,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               oe,
  output logic [WIDTH-1:0]   datain_h,
  output logic [WIDTH-1:0]   datain_l,
  input  logic [WIDTH-1:0]   dataout_h,
  input  logic [WIDTH-1:0]   dataout_l,
  output logic               outclkena,
  output logic               inclkena
);

  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  seq_state_e         state_q, state_d;
  dir_e               last_dir_q, last_dir_d;
  logic               wr_q, wr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]      turn_q, turn_d;
  logic               cmd_ready_q;
  logic               oe_q;
  logic [2*WIDTH-1:0] datain_q;
  logic               wr_ready_c;
  logic               pipe_active;
  logic               accept;
  logic               need_turn;

  assign accept    = cmd_valid && cmd_ready_q;
  assign need_turn = (TURNAROUND > 0) &&
                     ((cmd_write && (last_dir_q == DIR_READ)) ||
                      (!cmd_write && (last_dir_q == DIR_WRITE)));

  // Control state, burst counters and last bus direction.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_NONE;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      turn_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
    end
  end

  // Next-state logic; the beat counter holds remaining beats minus one so a
  // full MAX_BURST command never needs a value beyond MAX_BURST-1.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    turn_d     = turn_q;
    wr_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d   = cmd_write;
          cnt_d  = cmd_len;
          turn_d = '0;
          if (need_turn)      state_d = ST_TURN;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) state_d = wr_q ? ST_WRITE : ST_READ;
        else                     turn_d  = turn_q + 1'b1;
      end
      ST_WRITE: begin
        wr_ready_c = 1'b1;
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          last_dir_d = DIR_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == '0) state_d = ST_DRAIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DRAIN: begin
        // Leave once the last token is at the capture stage so the ready
        // handshake reopens right after the final rd_valid pulse.
        if (!pipe_active) begin
          state_d    = ST_IDLE;
          last_dir_d = DIR_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered pad drive and command-ready flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cmd_ready_q <= 1'b0;
      oe_q        <= 1'b0;
      datain_q    <= '0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      oe_q        <= wr_ready_c;
      if (wr_ready_c) begin
        datain_q <= wr_data;
      end
    end
  end

  ddio_rd_capture #(
    .WIDTH        (WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_capture (
    .clk           (clk),
    .areset_n      (areset_n),
    .push_i        (state_q == ST_READ),
    .dataout_h_i   (dataout_h),
    .dataout_l_i   (dataout_l),
    .pipe_active_o (pipe_active),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data)
  );

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_c;
  assign oe        = oe_q;
  assign datain_h  = datain_q[2*WIDTH-1:WIDTH];
  assign datain_l  = datain_q[WIDTH-1:0];
  assign outclkena = wr_ready_c | oe_q;
  assign inclkena  = pipe_active;
  assign busy      = (state_q != ST_IDLE) | pipe_active | rd_valid;

endmodule

// File: tb/tb_ddio_bidir_sequencer.sv
// Randomized self-checking bench for ddio_bidir_sequencer. Expected per-cycle
// behaviour is derived from each command's direction, length and the previous
// bus direction.
module tb_ddio_bidir_sequencer;

  localparam int W  = 8;
  localparam int TA = 2;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  dataout_h = '0;
  logic [7:0]  dataout_l = '0;
  logic        cmd_ready, wr_ready, rd_valid, busy, oe, outclkena, inclkena;
  logic [15:0] rd_data;
  logic [7:0]  datain_h, datain_l;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_last_dir = 0;   // 0 none, 1 read, 2 write
  int first_wr_cyc, last_wr_cyc;
  logic [15:0] w_hist [0:63];
  logic [15:0] p_hist [0:63];

  ddio_bidir_sequencer #(
    .WIDTH(W), .MAX_BURST(16), .TURNAROUND(TA), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .oe(oe), .datain_h(datain_h), .datain_l(datain_l),
    .dataout_h(dataout_h), .dataout_l(dataout_l),
    .outclkena(outclkena), .inclkena(inclkena)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

  // Issue one command and check every cycle until the sequencer is ready again.
  // abort_at >= 0 stops early at that cycle index (used for reset injection).
  task automatic exec_cmd(input bit wr, input int len, input bit pattern, input int abort_at);
    int t, last_i, pulses;
    bit issued;
    logic [6:0] exp_v, obs_v;
    t = ((wr && model_last_dir == 1) || (!wr && model_last_dir == 2)) ? TA : 0;
    last_i = wr ? (t + len + 1) : (t + len + RL + 2);
    issued = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_ready === 1'b1) begin issued = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!issued) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b after 100 cycles, required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_len = 4'(len);
    wr_data = 16'($urandom); {dataout_h, dataout_l} = 16'($urandom);
    @(negedge clk);
    pulses = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    for (int i = 0; i <= last_i; i++) begin
      if (i == abort_at) begin cmd_valid = 1'b0; return; end
      exp_v[6] = (i == last_i);
      exp_v[5] = (i < last_i);
      exp_v[4] = wr && (i >= t) && (i <= t + len);
      exp_v[3] = wr && (i >= t + 1) && (i <= t + len + 1);
      exp_v[2] = wr && (i >= t) && (i <= t + len + 1);
      exp_v[1] = !wr && (i >= t + 1) && (i <= t + len + RL);
      exp_v[0] = !wr && (i >= t + RL + 1) && (i <= t + len + RL + 1);
      obs_v = {cmd_ready, busy, wr_ready, oe, outclkena, inclkena, rd_valid};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL ctrl wr=%0d len=%0d i=%0d: got %b required %b (cmd_ready busy wr_ready oe outclkena inclkena rd_valid)",
                 wr, len, i, obs_v, exp_v);
      end
      if (exp_v[3]) begin
        n_checks++;
        if ({datain_h, datain_l} !== w_hist[i-1]) begin
          n_fail++;
          $display("FAIL datain len=%0d i=%0d: got %h required %h", len, i, {datain_h, datain_l}, w_hist[i-1]);
        end
      end
      if (exp_v[0]) begin
        n_checks++;
        if (rd_data !== p_hist[i-1]) begin
          n_fail++;
          $display("FAIL rd_data len=%0d i=%0d: got %h required %h", len, i, rd_data, p_hist[i-1]);
        end
      end
      if (rd_valid === 1'b1) pulses++;
      if (wr_ready === 1'b1) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (i == last_i) begin cmd_valid = 1'b0; break; end
      // Junk commands while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom); cmd_len = 4'($urandom);
      if (pattern && wr && (i >= t) && (i <= t + len)) w_hist[i] = 16'(16'h0101 * (i - t + 1));
      else w_hist[i] = 16'($urandom);
      p_hist[i] = 16'($urandom);
      wr_data = w_hist[i];
      {dataout_h, dataout_l} = p_hist[i];
      @(negedge clk);
    end
    n_checks++;
    if (pulses != (wr ? 0 : len + 1)) begin
      n_fail++;
      $display("FAIL rd_pulses wr=%0d len=%0d: got %0d required %0d", wr, len, pulses, wr ? 0 : len + 1);
    end
    model_last_dir = wr ? 2 : 1;
  endtask

  task automatic test_reset;
    logic [38:0] obs;
    areset_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {cmd_ready, busy, wr_ready, oe, outclkena, inclkena, rd_valid, datain_h, datain_l, rd_data};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", obs);
    end
    areset_n = 1'b1;
    model_last_dir = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, oe, rd_valid, wr_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 0000", {busy, oe, rd_valid, wr_ready});
    end
  endtask

  task automatic test_write_len3;
    exec_cmd(1'b1, 3, 1'b1, -1);
  endtask

  task automatic test_write_then_read;
    exec_cmd(1'b1, 0, 1'b0, -1);
    exec_cmd(1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_max_bursts;
    exec_cmd(1'b0, 15, 1'b0, -1);
    exec_cmd(1'b1, 15, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    int prev_last;
    exec_cmd(1'b1, 2, 1'b0, -1);
    prev_last = last_wr_cyc;
    exec_cmd(1'b1, 5, 1'b0, -1);
    n_checks++;
    if (first_wr_cyc - prev_last != 2) begin
      n_fail++;
      $display("FAIL b2b_write_gap: got %0d cycles required 2", first_wr_cyc - prev_last);
    end
    exec_cmd(1'b0, 2, 1'b0, -1);
    exec_cmd(1'b0, 4, 1'b0, -1);
  endtask

  task automatic test_reset_mid_read;
    int t;
    logic [38:0] obs;
    t = (model_last_dir == 2) ? TA : 0;
    exec_cmd(1'b0, 7, 1'b0, t + 1);
    areset_n = 1'b0;
    #1;
    obs = {cmd_ready, busy, wr_ready, oe, outclkena, inclkena, rd_valid, datain_h, datain_l, rd_data};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got %h required 0", obs);
    end
    @(negedge clk);
    areset_n = 1'b1;
    model_last_dir = 0;
    for (int k = 0; k < 12; k++) begin
      {dataout_h, dataout_l} = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_rd_valid k=%0d: got %b required 0", k, rd_valid);
      end
    end
    exec_cmd(1'b0, 3, 1'b0, -1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 14; n++) begin
      exec_cmd(1'($urandom), int'($urandom_range(0, 15)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset;
    test_write_len3;
    test_write_then_read;
    test_max_bursts;
    test_back_to_back;
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
